// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state encoding
package uart_pkg;

  localparam int CLK_HZ       = 50_000_000;
  localparam int BAUD         = 115200;
  localparam int CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for the asynchronous rx pin, resets to idle-high
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; both reset high so a reset never looks like a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined)
module uart_rx #(
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk_50M,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  import uart_pkg::*;

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  rx_state_t            state;
  logic [CW-1:0]        clk_cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 rx_s;

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  logic perr_q;
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign busy = (state != IDLE);

  uart_rx_sync u_sync (
    .clk   (clk_50M),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  // Frame FSM: centres on the start bit, then samples every bit period mid-bit
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit   <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          clk_cnt <= '0;
          bit_idx <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (clk_cnt == HALF_CNT) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            // Line back high at mid start bit means it was only a glitch
            state   <= rx_s ? IDLE : DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (clk_cnt == LAST_CNT) begin
            clk_cnt <= '0;
            // Shift in from the top so the first (LSB) bit ends up in bit 0
            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            if (bit_idx == LAST_BIT) begin
              bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
              state   <= PARITY;
`else
              state   <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        PARITY: begin
`ifdef UART_RX_PARITY_EN
          if (clk_cnt == LAST_CNT) begin
            clk_cnt <= '0;
            par_bit <= rx_s;
            state   <= STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
`else
          state <= IDLE;
`endif
        end
        STOP: begin
          if (clk_cnt == LAST_CNT) begin
            clk_cnt <= '0;
            if (rx_s) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
              perr_q   <= (^shreg) ^ par_bit;
`endif
              state    <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        BREAK: begin
          clk_cnt <= '0;
          // Hold off until the line returns high so a long low is not read as a start bit
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx against a frame-level model
module tb_uart_rx;

  localparam int CPB = 434;
  localparam int DB  = 8;
`ifdef UART_RX_PARITY_EN
  localparam int EXP_LAT = 2 + (CPB / 2 - 1) + (DB + 1) * CPB + 1 + CPB;
`else
  localparam int EXP_LAT = 2 + (CPB / 2 - 1) + (DB + 1) * CPB + 1;
`endif

  logic          clk_50M = 1'b0;
  logic          rst_n;
  logic          rx;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          parity_err;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  int          cyc = 0;
  int          last_start = 0;
  int          valid_cyc = 0;
  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  model_last = 8'h00;
  int          ferr_cnt = 0;
  int          perr_cnt = 0;
  int          long_pulse = 0;
  bit          busy_seen = 0;
  logic        prev_valid = 1'b0;
  logic        prev_ferr = 1'b0;
`ifdef UART_RX_PARITY_EN
  bit          bad_par_g = 0;
`endif

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk_50M    (clk_50M),
    .rst_n      (rst_n),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #10 clk_50M = ~clk_50M;

  always @(posedge clk_50M) cyc++;

  always @(negedge clk_50M) begin
    if (rx_valid) begin
      got_q.push_back(rx_data);
      valid_cyc = cyc;
    end
    if (frame_err) ferr_cnt++;
    if (parity_err) perr_cnt++;
    if (busy) busy_seen = 1;
    if ((rx_valid && prev_valid) || (frame_err && prev_ferr)) long_pulse++;
    prev_valid = rx_valid;
    prev_ferr  = frame_err;
  end

  task automatic clr();
    got_q.delete();
    exp_q.delete();
    ferr_cnt  = 0;
    perr_cnt  = 0;
    busy_seen = 0;
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * CPB) @(negedge clk_50M);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    last_start = cyc;
    rx = 1'b0;
    repeat (CPB) @(negedge clk_50M);
    for (int i = 0; i < DB; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk_50M);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ bad_par_g;
    repeat (CPB) @(negedge clk_50M);
`endif
    rx = stop_bit;
    repeat (CPB) @(negedge clk_50M);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk_50M);
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%h want=00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b want=0", rx_valid); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b want=0", frame_err); end
    checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL reset_parity_err got=%b want=0", parity_err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    rst_n = 1'b1;
    clr();
    idle_bits(10);
    checks++; if (got_q.size() != 0 || ferr_cnt != 0 || busy_seen) begin
      failures++; $display("FAIL idle_quiet valids=%0d ferr=%0d busy_seen=%0d want=0/0/0", got_q.size(), ferr_cnt, busy_seen);
    end
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL idle_rx_data got=%h want=00", rx_data); end
  endtask

  task automatic test_single();
    clr();
    send_frame(8'h63, 1'b1);
    model_last = 8'h63;
    idle_bits(1);
    checks++; if (got_q.size() != 1) begin failures++; $display("FAIL single_count got=%0d want=1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 8'h63) begin failures++; $display("FAIL single_data got=%h want=63", got_q[0]); end
    end
    checks++; if (valid_cyc - last_start - 1 != EXP_LAT) begin
      failures++; $display("FAIL single_latency got=%0d want=%0d", valid_cyc - last_start - 1, EXP_LAT);
    end
  endtask

  task automatic test_back_to_back();
    clr();
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    model_last = 8'h3C;
    idle_bits(1);
    checks++; if (got_q.size() != 2) begin failures++; $display("FAIL b2b_count got=%0d want=2", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 8'hA5 || got_q[1] !== 8'h3C) begin
        failures++; $display("FAIL b2b_data got=%h,%h want=a5,3c", got_q[0], got_q[1]);
      end
    end
  endtask

  task automatic test_glitch();
    clr();
    rx = 1'b0;
    repeat (100) @(negedge clk_50M);
    idle_bits(2);
    checks++; if (got_q.size() != 0 || ferr_cnt != 0) begin
      failures++; $display("FAIL glitch_pulses valids=%0d ferr=%0d want=0/0", got_q.size(), ferr_cnt);
    end
    checks++; if (!busy_seen || busy !== 1'b0) begin
      failures++; $display("FAIL glitch_fsm busy_seen=%0d busy=%b want=1/0", busy_seen, busy);
    end
  endtask

  task automatic test_frame_err();
    clr();
    send_frame(8'h55, 1'b0);
    rx = 1'b0;
    repeat (3 * CPB) @(negedge clk_50M);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL break_busy got=%b want=1", busy); end
    idle_bits(2);
    checks++; if (ferr_cnt != 1 || got_q.size() != 0) begin
      failures++; $display("FAIL ferr_pulses ferr=%0d valids=%0d want=1/0", ferr_cnt, got_q.size());
    end
    checks++; if (rx_data !== model_last) begin failures++; $display("FAIL ferr_hold got=%h want=%h", rx_data, model_last); end
    clr();
    send_frame(8'h0F, 1'b1);
    model_last = 8'h0F;
    idle_bits(1);
    checks++; if (got_q.size() != 1 || rx_data !== 8'h0F) begin
      failures++; $display("FAIL after_ferr count=%0d data=%h want=1/0f", got_q.size(), rx_data);
    end
  endtask

  task automatic test_reset_mid();
    clr();
    rx = 1'b0;
    repeat (CPB) @(negedge clk_50M);
    rx = 1'b1;
    repeat (3 * CPB + 100) @(negedge clk_50M);
    rst_n = 1'b0;
    repeat (5) @(negedge clk_50M);
    checks++; if (busy !== 1'b0 || rx_data !== 8'h00) begin
      failures++; $display("FAIL midreset_state busy=%b data=%h want=0/00", busy, rx_data);
    end
    rst_n = 1'b1;
    model_last = 8'h00;
    idle_bits(7);
    checks++; if (got_q.size() != 0 || ferr_cnt != 0) begin
      failures++; $display("FAIL midreset_pulses valids=%0d ferr=%0d want=0/0", got_q.size(), ferr_cnt);
    end
    send_frame(8'h12, 1'b1);
    model_last = 8'h12;
    idle_bits(1);
    checks++; if (got_q.size() != 1 || rx_data !== 8'h12) begin
      failures++; $display("FAIL midreset_next count=%0d data=%h want=1/12", got_q.size(), rx_data);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    clr();
    for (int n = 0; n < 4; n++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_frame(b, 1'b1);
      model_last = b;
      idle_bits(int'($urandom_range(0, 1)));
    end
    idle_bits(1);
    checks++; if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL rand_count got=%0d want=%0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin
          failures++; $display("FAIL rand_data[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
        end
      end
    end
    checks++; if (rx_data !== model_last) begin failures++; $display("FAIL rand_last got=%h want=%h", rx_data, model_last); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    clr();
    bad_par_g = 1;
    send_frame(8'h07, 1'b1);
    bad_par_g = 0;
    idle_bits(1);
    checks++; if (got_q.size() != 1 || perr_cnt != 1 || rx_data !== 8'h07) begin
      failures++; $display("FAIL bad_parity valids=%0d perr=%0d data=%h want=1/1/07", got_q.size(), perr_cnt, rx_data);
    end
    clr();
    send_frame(8'h07, 1'b1);
    idle_bits(1);
    checks++; if (got_q.size() != 1 || perr_cnt != 0) begin
      failures++; $display("FAIL good_parity valids=%0d perr=%0d want=1/0", got_q.size(), perr_cnt);
    end
  endtask
`endif

  task automatic test_pulse_width();
    checks++; if (long_pulse != 0) begin failures++; $display("FAIL pulse_width long=%0d want=0", long_pulse); end
`ifndef UART_RX_PARITY_EN
    checks++; if (perr_cnt != 0 || parity_err !== 1'b0) begin
      failures++; $display("FAIL parity_tied perr=%0d want=0", perr_cnt);
    end
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    @(negedge clk_50M);
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_random();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_pulse_width();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
